// File: rtl/noc_axi4_bridge_pkg.sv
// Shared types and helpers for the NoC-AXI4 bridge serializer/deserializer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package noc_axi4_bridge_pkg;

    localparam int NOC_DATA_WIDTH   = 64;
    localparam int AXI4_DATA_WIDTH  = 512;
    localparam int FLITS_PER_AXI    = AXI4_DATA_WIDTH / NOC_DATA_WIDTH;
    localparam int PAYLOAD_LEN      = FLITS_PER_AXI;

    // MSG_LENGTH field location inside a NoC header flit
    localparam int MSG_LENGTH_WIDTH = 8;
    localparam int MSG_LENGTH_LO    = 22;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_HDR  = 2'd1,
        SEND_DATA = 2'd2
    } ser_state_e;

    // Byte-reverse one 64-bit flit
    function automatic logic [63:0] bswap64(input logic [63:0] d);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            r[b*8 +: 8] = d[(7-b)*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/noc_axi4_bridge_skid.sv
// 2-entry valid/ready skid buffer with registered outputs and registered in_rdy.
// Latency: 1 cycle from input handshake to output valid.
// Backpressure: out_rdy_i only feeds registers; a stalled beat parks in the skid slot.
module noc_axi4_bridge_skid #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    input  logic [WIDTH-1:0] in_dat_i,
    output logic             out_vld_o,
    input  logic             out_rdy_i,
    output logic [WIDTH-1:0] out_dat_o
);

    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_dat_q, out_dat_d;
    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] skid_dat_q, skid_dat_d;

    assign in_rdy_o  = ~skid_vld_q;
    assign out_vld_o = out_vld_q;
    assign out_dat_o = out_dat_q;

    // Refill the output stage when it drains; otherwise park new beats in the skid slot
    always_comb begin
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (!out_vld_q || out_rdy_i) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_dat_d  = skid_dat_q;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = in_vld_i;
                if (in_vld_i) begin
                    out_dat_d = in_dat_i;
                end
            end
        end else if (in_vld_i && !skid_vld_q) begin
            skid_vld_d = 1'b1;
            skid_dat_d = in_dat_i;
        end
    end

    // Buffer state; reset empties both entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
        end
    end

endmodule

// File: rtl/noc_axi4_bridge_resp_ser.sv
// Serializes one header + one AXI data word into header flit + MSG_LENGTH payload flits.
// Latency: header valid 1 cycle after capture (2 with NOC_AXI4_BRIDGE_SER_REG_OUT_EN), then 1 flit/cycle.
// Backpressure: flit_out held stable while stalled; in_rdy depends on FSM state only.
module noc_axi4_bridge_resp_ser
    import noc_axi4_bridge_pkg::*;
#(
    parameter int SWAP_ENDIANESS    = 0,
    parameter int AXI2NOC_SER_ORDER = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NOC_DATA_WIDTH-1:0]  header_in,
    input  logic [AXI4_DATA_WIDTH-1:0] data_in,
    input  logic                       in_val,
    output logic                       in_rdy,
    output logic [NOC_DATA_WIDTH-1:0]  flit_out,
    output logic                       flit_out_val,
    input  logic                       flit_out_rdy
);

    ser_state_e                  state_q, state_d;
    logic [NOC_DATA_WIDTH-1:0]   hdr_q, hdr_d;
    logic [AXI4_DATA_WIDTH-1:0]  data_q, data_d;
    logic [MSG_LENGTH_WIDTH-1:0] rem_q, rem_d;
    logic [MSG_LENGTH_WIDTH-1:0] idx_q, idx_d;
    logic [MSG_LENGTH_WIDTH-1:0] chunk;
    logic [NOC_DATA_WIDTH-1:0]   payload_raw, payload;
    logic                        ser_vld, ser_rdy;
    logic [NOC_DATA_WIDTH-1:0]   ser_dat;

    // Pick payload chunk for the current flit index; oversized lengths pad with zeros
    always_comb begin
        chunk       = (AXI2NOC_SER_ORDER != 0) ? (MSG_LENGTH_WIDTH'(PAYLOAD_LEN - 1) - idx_q) : idx_q;
        payload_raw = '0;
        for (int i = 0; i < PAYLOAD_LEN; i++) begin
            if (idx_q < MSG_LENGTH_WIDTH'(PAYLOAD_LEN) && chunk == MSG_LENGTH_WIDTH'(i)) begin
                payload_raw = data_q[i*NOC_DATA_WIDTH +: NOC_DATA_WIDTH];
            end
        end
        payload = (SWAP_ENDIANESS != 0) ? bswap64(payload_raw) : payload_raw;
    end

    // Next-state and flit source selection
    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        data_d  = data_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        in_rdy  = 1'b0;
        ser_vld = 1'b0;
        ser_dat = '0;
        case (state_q)
            IDLE: begin
                in_rdy = 1'b1;
                if (in_val) begin
                    hdr_d   = header_in;
                    data_d  = data_in;
                    rem_d   = header_in[MSG_LENGTH_LO +: MSG_LENGTH_WIDTH];
                    idx_d   = '0;
                    state_d = SEND_HDR;
                end
            end
            SEND_HDR: begin
                ser_vld = 1'b1;
                ser_dat = hdr_q;
                if (ser_rdy) begin
                    state_d = (rem_q != '0) ? SEND_DATA : IDLE;
                end
            end
            SEND_DATA: begin
                ser_vld = 1'b1;
                ser_dat = payload;
                if (ser_rdy) begin
                    idx_d = idx_q + MSG_LENGTH_WIDTH'(1);
                    rem_d = rem_q - MSG_LENGTH_WIDTH'(1);
                    if (rem_q == MSG_LENGTH_WIDTH'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hdr_q   <= '0;
            data_q  <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
        end
    end

`ifdef NOC_AXI4_BRIDGE_SER_REG_OUT_EN
    noc_axi4_bridge_skid #(
        .WIDTH(NOC_DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld_i (ser_vld),
        .in_rdy_o (ser_rdy),
        .in_dat_i (ser_dat),
        .out_vld_o(flit_out_val),
        .out_rdy_i(flit_out_rdy),
        .out_dat_o(flit_out)
    );
`else
    assign ser_rdy      = flit_out_rdy;
    assign flit_out_val = ser_vld;
    assign flit_out     = ser_dat;
`endif

endmodule

// File: tb/tb_noc_axi4_bridge_resp_ser.sv
// Directed bench for the response serializer (default and ORDER=1/SWAP=1 instances).
// Latency: checks default-build timing (header 1 cycle after capture).
// Backpressure: exercises random flit_out_rdy and stall stability.
module tb_noc_axi4_bridge_resp_ser;
    import noc_axi4_bridge_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [63:0]  header_in = '0;
    logic [511:0] data_in = '0;
    logic         in_val0 = 1'b0, in_val1 = 1'b0;
    logic         in_rdy0, in_rdy1;
    logic [63:0]  flit_out0, flit_out1;
    logic         flit_out_val0, flit_out_val1;
    logic         flit_out_rdy = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    noc_axi4_bridge_resp_ser #(.SWAP_ENDIANESS(0), .AXI2NOC_SER_ORDER(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .header_in(header_in), .data_in(data_in),
        .in_val(in_val0), .in_rdy(in_rdy0), .flit_out(flit_out0),
        .flit_out_val(flit_out_val0), .flit_out_rdy(flit_out_rdy)
    );

    noc_axi4_bridge_resp_ser #(.SWAP_ENDIANESS(1), .AXI2NOC_SER_ORDER(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .header_in(header_in), .data_in(data_in),
        .in_val(in_val1), .in_rdy(in_rdy1), .flit_out(flit_out1),
        .flit_out_val(flit_out_val1), .flit_out_rdy(flit_out_rdy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_hdr(input logic [7:0] len);
        return 64'hABCD_0000_0000_1234 | (64'(len) << 22);
    endfunction

    // Present one message for a single cycle; returns at the negedge where the header should show
    task automatic send(input bit which, input logic [63:0] hdr, input logic [511:0] dat);
        @(negedge clk);
        chk("in_rdy_idle", which ? in_rdy1 : in_rdy0, 64'd1);
        header_in = hdr;
        data_in   = dat;
        if (which) in_val1 = 1'b1; else in_val0 = 1'b1;
        @(negedge clk);
        in_val0   = 1'b0;
        in_val1   = 1'b0;
        header_in = {$urandom, $urandom};
        data_in   = {16{$urandom}};
    endtask

    // Check the flit visible now (flit_out_rdy=1), then step one cycle
    task automatic expect_flit(input bit which, input string tag, input logic [63:0] exp);
        chk({tag, "_val"}, which ? flit_out_val1 : flit_out_val0, 64'd1);
        chk(tag, which ? flit_out1 : flit_out0, exp);
        @(negedge clk);
    endtask

    logic [511:0] pat1, pat3, pat4, pat5;
    logic [63:0]  bp_exp [9];
    logic [63:0]  prev_flit;
    bit           stalled_prev;
    int           n_rx;
    bit           r;

    initial begin
        for (int i = 0; i < 8; i++) begin
            pat1[i*64 +: 64] = 64'h1111_1111_1111_1111 * i;
            pat3[i*64 +: 64] = {32'hC0DE_0000 + i, 32'h5A5A_0000 + i};
            pat5[i*64 +: 64] = 64'hFEED_0000_0000_0000 + i;
        end
        for (int i = 0; i < 6; i++) pat4[i*64 +: 64] = 64'h1111_1111_1111_1111 * i;
        pat4[6*64 +: 64] = 64'h0000_0000_0000_00AB;
        pat4[7*64 +: 64] = 64'h0102_0304_0506_0708;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_val", flit_out_val0, 64'd0);
        chk("rst_flit", flit_out0, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_rdy0", in_rdy0, 64'd1);
        chk("post_rst_in_rdy1", in_rdy1, 64'd1);
        chk("post_rst_val1", flit_out_val1, 64'd0);

        // Full packet, length 8
        send(0, mk_hdr(8'd8), pat1);
        chk("full_in_rdy_busy", in_rdy0, 64'd0);
        expect_flit(0, "full_hdr", mk_hdr(8'd8));
        for (int k = 0; k < 8; k++) expect_flit(0, $sformatf("full_d%0d", k), 64'h1111_1111_1111_1111 * k);
        chk("full_in_rdy_back", in_rdy0, 64'd1);
        chk("full_idle_val", flit_out_val0, 64'd0);

        // Header only
        send(0, mk_hdr(8'd0), {16{32'hDEAD_BEEF}});
        expect_flit(0, "hdronly_hdr", mk_hdr(8'd0));
        chk("hdronly_idle_val", flit_out_val0, 64'd0);
        chk("hdronly_in_rdy", in_rdy0, 64'd1);

        // Random backpressure, length 8
        bp_exp[0] = mk_hdr(8'd8);
        for (int k = 0; k < 8; k++) bp_exp[k+1] = {32'hC0DE_0000 + k, 32'h5A5A_0000 + k};
        send(0, mk_hdr(8'd8), pat3);
        n_rx = 0;
        stalled_prev = 1'b0;
        prev_flit = '0;
        for (int cyc = 0; cyc < 300 && n_rx < 9; cyc++) begin
            if (stalled_prev) begin
                chk("bp_hold_val", flit_out_val0, 64'd1);
                chk("bp_hold_flit", flit_out0, prev_flit);
            end
            r = 1'($urandom_range(0, 1));
            flit_out_rdy = r;
            if (flit_out_val0 && r) begin
                chk($sformatf("bp_flit%0d", n_rx), flit_out0, bp_exp[n_rx]);
                n_rx++;
            end
            stalled_prev = flit_out_val0 && !r;
            prev_flit    = flit_out0;
            if (n_rx < 9) @(negedge clk);
        end
        chk("bp_count", 64'(n_rx), 64'd9);
        flit_out_rdy = 1'b1;
        @(negedge clk);
        chk("bp_idle_val", flit_out_val0, 64'd0);
        chk("bp_in_rdy", in_rdy0, 64'd1);

        // ORDER=1 with byte swap
        send(1, mk_hdr(8'd8), pat4);
        expect_flit(1, "os_hdr", mk_hdr(8'd8));
        expect_flit(1, "os_d0", 64'h0807_0605_0403_0201);
        expect_flit(1, "os_d1", 64'hAB00_0000_0000_0000);
        expect_flit(1, "os_d2", 64'h5555_5555_5555_5555);
        for (int k = 3; k < 8; k++) begin
            chk($sformatf("os_d%0d_val", k), flit_out_val1, 64'd1);
            @(negedge clk);
        end
        chk("os_idle_val", flit_out_val1, 64'd0);
        chk("os_in_rdy", in_rdy1, 64'd1);

        // Reset mid-packet after the third data flit
        send(0, mk_hdr(8'd8), pat1);
        expect_flit(0, "rm_hdr", mk_hdr(8'd8));
        for (int k = 0; k < 3; k++) expect_flit(0, $sformatf("rm_d%0d", k), 64'h1111_1111_1111_1111 * k);
        rst_n = 1'b0;
        #1;
        chk("rm_val_drop", flit_out_val0, 64'd0);
        chk("rm_flit_zero", flit_out0, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, mk_hdr(8'd2), pat5);
        expect_flit(0, "rm2_hdr", mk_hdr(8'd2));
        expect_flit(0, "rm2_d0", 64'hFEED_0000_0000_0000);
        expect_flit(0, "rm2_d1", 64'hFEED_0000_0000_0001);
        chk("rm2_idle_val", flit_out_val0, 64'd0);

        // Oversized length 10: eight chunks then two zero flits
        send(0, mk_hdr(8'd10), pat1);
        expect_flit(0, "ov_hdr", mk_hdr(8'd10));
        for (int k = 0; k < 8; k++) expect_flit(0, $sformatf("ov_d%0d", k), 64'h1111_1111_1111_1111 * k);
        expect_flit(0, "ov_pad0", 64'd0);
        expect_flit(0, "ov_pad1", 64'd0);
        chk("ov_idle_val", flit_out_val0, 64'd0);
        chk("ov_in_rdy", in_rdy0, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_axi4_bridge_resp_ser.md
# noc_axi4_bridge_resp_ser

Response-path serializer of the NoC–AXI4 bridge. Accepts one response message per handshake: a single NoC header flit plus one full AXI4 data word. Emits it on the NoC as the header flit followed by `MSG_LENGTH` payload flits. It is the transmit counterpart of the bridge's request deserializer and sits between the AXI read/write-response logic and the outgoing NoC channel.

## Interface

Parameters:
- `SWAP_ENDIANESS`, default 0: when 1, byte-reverse each 64-bit payload flit before emission; the header is never swapped.
- `AXI2NOC_SER_ORDER`, default 0: flit-to-AXI-chunk mapping (see Operation).

Ports:
- `clk`, input, 1: single clock. Asynchronous reset, active low.
- `rst_n`, input, 1: asynchronous active-low reset.
- `header_in`, input, `NOC_DATA_WIDTH`: response header flit; `MSG_LENGTH` field gives the payload flit count.
- `data_in`, input, `AXI4_DATA_WIDTH`: response data word; ignored when the length is 0.
- `in_val`, input, 1: header_in/data_in valid.
- `in_rdy`, output, 1: block can capture a message.
- `flit_out`, output, `NOC_DATA_WIDTH`: outgoing NoC flit.
- `flit_out_val`, output, 1: flit_out valid.
- `flit_out_rdy`, input, 1: NoC accepts flit.

## Operation

- States: IDLE, SEND_HDR, SEND_DATA.
- IDLE:
  - `in_rdy`=1.
  - On `in_val & in_rdy`: capture header_in into the header register, data_in into the data register, and `header_in[MSG_LENGTH]` into `remaining`.
  - Clear the flit index `idx` to 0, then go to SEND_HDR.
- SEND_HDR:
  - `flit_out` = header register, `flit_out_val`=1.
  - On accept: go to SEND_DATA if `remaining`≠0, else IDLE.
- SEND_DATA:
  - `flit_out` = payload flit `idx`, `flit_out_val`=1.
  - On accept: `idx`+1 and `remaining`−1.
  - When accepting with `remaining`==1, go to IDLE.
- Payload flit `idx` selection:
  - `AXI2NOC_SER_ORDER`=0: chunk `data[idx*NOC_DATA_WIDTH +: NOC_DATA_WIDTH]`.
  - `AXI2NOC_SER_ORDER`=1: chunk `PAYLOAD_LEN-1-idx`.
- Length above `PAYLOAD_LEN` (protocol error):
  - Exactly `MSG_LENGTH` payload flits are still sent.
  - Flits with `idx` ≥ `PAYLOAD_LEN` are all-zero, so the NoC framing is preserved.
- `remaining` and `idx` are `MSG_LENGTH_WIDTH` wide, with no wrap for legal lengths.
- Stalls: while `flit_out_val`=1 and `flit_out_rdy`=0, `flit_out` is held stable. The block never withdraws valid.
- Capture registers load only in IDLE. Input changes outside the handshake are ignored.

## Timing

- Reset values: state=IDLE, `in_rdy`=1 (once reset deasserts), `flit_out_val`=0, `flit_out`=0, `remaining`=0, `idx`=0.
- Reset asserted mid-packet: `flit_out_val` drops immediately (asynchronous) and the partial packet is discarded. The next packet starts at its header.
- Capture at cycle T: header valid at T+1. With `flit_out_rdy` held at 1, data flit k is valid at T+2+k.
- After the last flit is accepted at cycle X, `in_rdy`=1 at X+1. Peak throughput is one message per L+2 cycles.
- `in_rdy` is a function of state only and has no combinational path from `flit_out_rdy`.

## Configuration

- `NOC_AXI4_BRIDGE_SER_REG_OUT_EN` defined:
  - `flit_out`/`flit_out_val` come from a 2-entry skid buffer with registered outputs, and `flit_out_rdy` only feeds registers.
  - Header is valid at T+2 and all latencies are +1. Full throughput is kept under continuous `flit_out_rdy`.
  - Reset empties the buffer.
- Undefined: outputs are driven directly from the state and data registers, with latencies as in Timing.

## Structure

- Shared package `noc_axi4_bridge_pkg` holds:
  - The state enum typedef.
  - `FLITS_PER_AXI` = `AXI4_DATA_WIDTH/NOC_DATA_WIDTH`.
  - The byte-swap function for a 64-bit flit.
- Sub-module `noc_axi4_bridge_skid`: 2-entry valid/ready skid buffer, instantiated only under `NOC_AXI4_BRIDGE_SER_REG_OUT_EN`.

## Test plan

- **Full packet:** length 8, data chunk i = 64'h1111_1111_1111_1111*i, ORDER=0, `flit_out_rdy`=1 → header, then chunks 0..7 on consecutive cycles; `in_rdy` reasserts one cycle after the last flit.
- **Header only:** length 0 → header only, back to IDLE, data_in ignored.
- **Random backpressure:** `flit_out_rdy` random 50%, length 8 → no flit dropped or duplicated, and `flit_out` stable during stalls.
- **Order and swap:** ORDER=1 with SWAP_ENDIANESS=1, chunk 7 = 64'h0102030405060708 → first data flit = 64'h0807060504030201.
- **Reset mid-packet:** `rst_n` low after the 3rd data flit → `flit_out_val`=0 at once; the next message is emitted cleanly from its header.
- **Oversized length:** length 10 → 8 chunk flits followed by 2 zero flits, with the header unchanged.
